// File: rtl/if_ctrl_pkg.sv
// rtl/if_ctrl_pkg.sv - state encodings and host command bytes for the IF program sequencer
package if_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_START_C = 3'd3,
        S_START_S = 3'd4,
        S_RUN     = 3'd5,
        S_STEP    = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_QUIT = 8'h51;

endpackage

// File: rtl/if_ctrl_word_asm.sv
// rtl/if_ctrl_word_asm.sv - assembles LSB-first bytes into one instruction word
module if_ctrl_word_asm #(
    parameter int DATA_BITS = 32,
    parameter int BYTE_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [BYTE_BITS-1:0] i_byte,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_word_done
);

    logic [1:0]           r_byte_count;
    logic [DATA_BITS-1:0] r_shift;

    // New bytes enter at the top so the first byte ends up in the least significant lane.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_byte_count <= 2'd0;
            r_shift      <= '0;
        end else if (i_clear) begin
            r_byte_count <= 2'd0;
            r_shift      <= '0;
        end else if (i_byte_valid) begin
            r_byte_count <= r_byte_count + 2'd1;
            r_shift      <= {i_byte, r_shift[DATA_BITS-1:BYTE_BITS]};
        end
    end

    assign o_word_done = i_byte_valid && !i_clear && (r_byte_count == 2'd3);
    assign o_word      = r_shift;

endmodule

// File: rtl/if_program_ctrl.sv
// rtl/if_program_ctrl.sv - host-driven load/run/step sequencer for the IF stage
// Single-step mode ('S', 'N', 'Q') is built only when IF_CTRL_STEP_EN is defined.
module if_program_ctrl
    import if_ctrl_pkg::*;
#(
    parameter  int                   DATA_BITS         = 32,
    parameter  int                   BYTE_BITS         = 8,
    parameter  int                   MEM_SIZE_IN_WORDS = 20,
    parameter  logic [DATA_BITS-1:0] HALT_INSTR        = '0,
    localparam int                   WC_BITS           = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [BYTE_BITS-1:0] i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    input  logic                 i_full_mem,
    input  logic                 i_empty_mem,
    input  logic                 i_end_program,
    output logic                 o_write_mem,
    output logic [DATA_BITS-1:0] o_instruction,
    output logic                 o_start,
    output logic                 o_enable,
    output logic                 o_halt,
    output logic [2:0]           o_state,
    output logic                 o_load_error,
    output logic [WC_BITS-1:0]   o_word_count
);

    localparam logic [WC_BITS-1:0] WC_MAX = WC_BITS'(MEM_SIZE_IN_WORDS);

    state_t               r_state;
    logic                 r_rx_ready;
    logic                 r_write_mem;
    logic                 r_start;
    logic                 r_enable;
    logic                 r_halt;
    logic                 r_load_error;
    logic [WC_BITS-1:0]   r_word_count;

    logic                 w_accept;
    logic                 w_load_byte;
    logic                 w_asm_clear;
    logic                 w_word_done;
    logic [DATA_BITS-1:0] w_word;

    assign w_accept    = i_rx_valid && r_rx_ready;
    assign w_load_byte = w_accept && (r_state == S_LOAD);
    assign w_asm_clear = w_accept && (r_state == S_IDLE) && (i_rx_data == CMD_LOAD);

    if_ctrl_word_asm #(
        .DATA_BITS (DATA_BITS),
        .BYTE_BITS (BYTE_BITS)
    ) u_word_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_load_byte),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_done  (w_word_done)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_rx_ready   <= 1'b1;
            r_write_mem  <= 1'b0;
            r_start      <= 1'b0;
            r_enable     <= 1'b0;
            r_halt       <= 1'b0;
            r_load_error <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_write_mem <= 1'b0;
            r_start     <= 1'b0;
            r_halt      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_rx_data == CMD_LOAD) begin
                            r_state      <= S_LOAD;
                            r_word_count <= '0;
                            r_load_error <= 1'b0;
                        end else if (i_rx_data == CMD_CONT && !i_empty_mem) begin
                            r_state    <= S_START_C;
                            r_start    <= 1'b1;
                            r_rx_ready <= 1'b0;
                        end
`ifdef IF_CTRL_STEP_EN
                        else if (i_rx_data == CMD_STEP && !i_empty_mem) begin
                            r_state    <= S_START_S;
                            r_start    <= 1'b1;
                            r_rx_ready <= 1'b0;
                        end
`endif
                    end
                end
                S_LOAD: begin
                    if (w_word_done) begin
                        r_state     <= S_WRITE;
                        r_write_mem <= 1'b1;
                        r_rx_ready  <= 1'b0;
                        if (r_word_count != WC_MAX) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                    end
                end
                // The halt word ends a load cleanly even if it also filled memory.
                S_WRITE: begin
                    r_rx_ready <= 1'b1;
                    if (w_word == HALT_INSTR) begin
                        r_state <= S_IDLE;
                    end else if (i_full_mem) begin
                        r_load_error <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_START_C: begin
                    r_state  <= S_RUN;
                    r_enable <= 1'b1;
                end
                S_RUN: begin
                    if (i_end_program) begin
                        r_enable <= 1'b0;
                        r_halt   <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
`ifdef IF_CTRL_STEP_EN
                S_START_S: begin
                    r_state    <= S_STEP;
                    r_rx_ready <= 1'b1;
                end
                // End of program outranks a simultaneous 'N'.
                S_STEP: begin
                    r_enable <= 1'b0;
                    if (i_end_program || (w_accept && i_rx_data == CMD_QUIT)) begin
                        r_halt     <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_state    <= S_HALT;
                    end else if (w_accept && i_rx_data == CMD_NEXT) begin
                        r_enable <= 1'b1;
                    end
                end
`endif
                S_HALT: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b1;
                    r_enable   <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_ready    = r_rx_ready;
    assign o_write_mem   = r_write_mem;
    assign o_instruction = w_word;
    assign o_start       = r_start;
    assign o_enable      = r_enable;
    assign o_halt        = r_halt;
    assign o_state       = r_state;
    assign o_load_error  = r_load_error;
    assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_if_program_ctrl.sv
// tb/tb_if_program_ctrl.sv - randomized self-checking bench for if_program_ctrl with a mode-level reference model
module tb_if_program_ctrl;
    import if_ctrl_pkg::*;

`ifdef IF_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        i_full_mem;
    logic        i_empty_mem;
    logic        i_end_program;
    logic        o_write_mem;
    logic [31:0] o_instruction;
    logic        o_start;
    logic        o_enable;
    logic        o_halt;
    logic [2:0]  o_state;
    logic        o_load_error;
    logic [4:0]  o_word_count;

    if_program_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_rx_ready    (o_rx_ready),
        .i_full_mem    (i_full_mem),
        .i_empty_mem   (i_empty_mem),
        .i_end_program (i_end_program),
        .o_write_mem   (o_write_mem),
        .o_instruction (o_instruction),
        .o_start       (o_start),
        .o_enable      (o_enable),
        .o_halt        (o_halt),
        .o_state       (o_state),
        .o_load_error  (o_load_error),
        .o_word_count  (o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: host-visible modes, with outputs derived from the mode.
    localparam int M_IDLE = 0, M_LOAD = 1, M_WRITE = 2, M_RUN_PRE = 3, M_STEP_PRE = 4,
                   M_RUN = 5, M_STEP = 6, M_HALTING = 7;
    int          m_mode;
    int          m_nb;
    logic [7:0]  m_bytes [0:2];
    logic [31:0] m_instr;
    logic        m_write, m_start, m_halt, m_pulse, m_err;
    int          m_wc;
    logic        m_rx_ready, m_enable, m_acc;

    assign m_rx_ready = (m_mode == M_IDLE) || (m_mode == M_LOAD) || (m_mode == M_STEP);
    assign m_enable   = (m_mode == M_RUN) || m_pulse;
    assign m_acc      = i_rx_valid && m_rx_ready;

    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            m_mode <= M_IDLE; m_nb <= 0; m_instr <= '0; m_write <= 1'b0; m_start <= 1'b0;
            m_halt <= 1'b0; m_pulse <= 1'b0; m_err <= 1'b0; m_wc <= 0;
        end else begin
            m_write <= 1'b0; m_start <= 1'b0; m_halt <= 1'b0; m_pulse <= 1'b0;
            case (m_mode)
                M_IDLE: if (m_acc) begin
                    if (i_rx_data == 8'h4C) begin
                        m_mode <= M_LOAD; m_wc <= 0; m_err <= 1'b0; m_nb <= 0;
                    end else if (!i_empty_mem && i_rx_data == 8'h43) begin
                        m_mode <= M_RUN_PRE; m_start <= 1'b1;
                    end else if (!i_empty_mem && STEP_EN && i_rx_data == 8'h53) begin
                        m_mode <= M_STEP_PRE; m_start <= 1'b1;
                    end
                end
                M_LOAD: if (m_acc) begin
                    if (m_nb == 3) begin
                        m_instr <= {i_rx_data, m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_write <= 1'b1;
                        m_mode  <= M_WRITE;
                        m_wc    <= (m_wc < 20) ? m_wc + 1 : m_wc;
                        m_nb    <= 0;
                    end else begin
                        m_bytes[m_nb] <= i_rx_data;
                        m_nb <= m_nb + 1;
                    end
                end
                M_WRITE: begin
                    if (m_instr == 32'h0) m_mode <= M_IDLE;
                    else if (i_full_mem) begin m_err <= 1'b1; m_mode <= M_IDLE; end
                    else m_mode <= M_LOAD;
                end
                M_RUN_PRE:  m_mode <= M_RUN;
                M_STEP_PRE: m_mode <= M_STEP;
                M_RUN: if (i_end_program) begin m_halt <= 1'b1; m_mode <= M_HALTING; end
                M_STEP: begin
                    if (i_end_program || (m_acc && i_rx_data == 8'h51)) begin
                        m_halt <= 1'b1; m_mode <= M_HALTING;
                    end else if (m_acc && i_rx_data == 8'h4E) begin
                        m_pulse <= 1'b1;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    int          cnt_write = 0, cnt_start = 0, cnt_halt = 0, cnt_en = 0;
    logic [31:0] wlog [$];

    always @(negedge i_clk) begin
        if (i_reset) begin
            chk("rx_ready", o_rx_ready, m_rx_ready);
            chk("write_mem", o_write_mem, m_write);
            chk("start", o_start, m_start);
            chk("halt", o_halt, m_halt);
            chk("enable", o_enable, m_enable);
            chk("word_count", o_word_count, m_wc);
            chk("load_error", o_load_error, m_err);
            chk("pulse_exclusive", (o_write_mem + o_start + o_halt) <= 1, 1);
            if (m_write) chk("instruction", o_instruction, m_instr);
            if (o_write_mem) begin cnt_write++; wlog.push_back(o_instruction); end
            if (o_start)  cnt_start++;
            if (o_halt)   cnt_halt++;
            if (o_enable) cnt_en++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 50) begin tick(1); n++; end
        if (n == 50) chk("rx_ready_timeout", 0, 1);
        tick(1);
        i_rx_valid = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b_w, b_s, b_h, b_e;
    logic [7:0] picks [0:7];

    initial begin
        i_reset = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0;
        i_full_mem = 1'b0; i_empty_mem = 1'b0; i_end_program = 1'b0;
        tick(2);
        chk("reset_rx_ready", o_rx_ready, 1);
        chk("reset_write", o_write_mem, 0);
        chk("reset_start", o_start, 0);
        chk("reset_enable", o_enable, 0);
        chk("reset_halt", o_halt, 0);
        chk("reset_state", o_state, S_IDLE);
        chk("reset_word_count", o_word_count, 0);
        i_reset = 1'b1;
        tick(1);

        // Reset in the middle of a load
        b_w = cnt_write;
        send_byte(8'h4C); send_byte(8'h78); send_byte(8'h56);
        i_reset = 1'b0; tick(2); i_reset = 1'b1; tick(5);
        chk("midload_no_write", cnt_write - b_w, 0);
        chk("midload_state", o_state, S_IDLE);
        chk("midload_rx_ready", o_rx_ready, 1);

        // Two-word load terminated by the halt word
        b_w = wlog.size();
        send_byte(8'h4C); send_word(32'h12345678); send_word(32'h0);
        tick(3);
        chk("load2_writes", wlog.size() - b_w, 2);
        chk("load2_word0", wlog[b_w], 32'h12345678);
        chk("load2_word1", wlog[b_w + 1], 32'h0);
        chk("load2_count", o_word_count, 2);
        chk("load2_error", o_load_error, 0);
        chk("load2_state", o_state, S_IDLE);

        // Memory fills before the halt word
        b_w = cnt_write;
        send_byte(8'h4C);
        for (int i = 0; i < 20; i++) begin
            if (i == 19) i_full_mem = 1'b1;
            send_word($urandom | 32'h1);
        end
        tick(3);
        i_full_mem = 1'b0;
        chk("full_writes", cnt_write - b_w, 20);
        chk("full_error", o_load_error, 1);
        chk("full_count", o_word_count, 20);
        chk("full_state", o_state, S_IDLE);

        // Continuous run
        b_s = cnt_start; b_h = cnt_halt;
        send_byte(8'h43);
        tick(6);
        chk("run_enable", o_enable, 1);
        i_end_program = 1'b1; tick(1); i_end_program = 1'b0;
        tick(4);
        chk("run_starts", cnt_start - b_s, 1);
        chk("run_halts", cnt_halt - b_h, 1);
        chk("run_state", o_state, S_IDLE);
        chk("run_enable_off", o_enable, 0);

        // Run command with empty memory
        b_s = cnt_start;
        i_empty_mem = 1'b1;
        send_byte(8'h43); tick(3);
        i_empty_mem = 1'b0;
        chk("empty_starts", cnt_start - b_s, 0);
        chk("empty_state", o_state, S_IDLE);

        // Single-step sequence
        b_s = cnt_start; b_h = cnt_halt; b_e = cnt_en;
        send_byte(8'h53); send_byte(8'h4E); send_byte(8'h4E); send_byte(8'h4E); send_byte(8'h51);
        tick(3);
        chk("step_starts", cnt_start - b_s, STEP_EN ? 1 : 0);
        chk("step_enable_cycles", cnt_en - b_e, STEP_EN ? 3 : 0);
        chk("step_halts", cnt_halt - b_h, STEP_EN ? 1 : 0);
        chk("step_state", o_state, S_IDLE);

        // Random soak against the model
        picks[0] = 8'h4C; picks[1] = 8'h43; picks[2] = 8'h53; picks[3] = 8'h4E;
        picks[4] = 8'h51; picks[5] = 8'h00; picks[6] = 8'hA5; picks[7] = 8'h4C;
        for (int c = 0; c < 600; c++) begin
            i_rx_valid    = 1'($urandom_range(0, 1));
            i_rx_data     = (c % 5 == 0) ? 8'($urandom) : picks[$urandom_range(0, 7)];
            i_full_mem    = ($urandom_range(0, 5) == 0);
            i_empty_mem   = ($urandom_range(0, 7) == 0);
            i_end_program = ($urandom_range(0, 9) == 0);
            tick(1);
        end
        i_rx_valid = 1'b0; i_full_mem = 1'b0; i_empty_mem = 1'b0; i_end_program = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
